// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// The optional autorepeat feature (KEYPAD_AUTOREPEAT_EN) uses the repeat constants below.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // Scans from acceptance to the first repeat, then scans between repeats.
    localparam int AUTOREPEAT_DELAY  = 32;
    localparam int AUTOREPEAT_PERIOD = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        ACCEPT,
        HELD
    } keypad_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_class_t;

endpackage

// File: rtl/keypad_scanner_synchroniser.sv
// keypad_synchroniser: generic two-flop synchroniser with asynchronous active-low
// reset and a configurable reset value, for any slow asynchronous input bus.
module keypad_synchroniser #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops give metastability time to resolve.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign data_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes the rows of a 4x4 matrix keypad, debounces whole scans
// and reports one key code per press with a single-cycle key_valid pulse.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid while one key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [ROWS-1:0] row_n,
    input  logic [COLS-1:0] col_n,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE_SCANS);

    logic [SCAN_DIV_BITS-1:0] div_q;
    logic [1:0]               row_q;
    logic [ROWS-1:0]          row_n_q;
    logic [COLS-1:0]          col_sync;
    logic                     terminal;
    logic                     scan_done;

    // Accumulated result of the scan in progress: key count (2 means two or more).
    logic [1:0]  acc_cnt_q,  acc_cnt_d;
    logic [3:0]  acc_code_q, acc_code_d;
    scan_class_t scan_class;

    keypad_state_t state_q;
    logic [3:0]    cand_q;
    logic [3:0]    cnt_q;
    logic [3:0]    rel_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [5:0]    rpt_q;
`endif

    keypad_synchroniser #(
        .WIDTH     (COLS),
        .RESET_VAL (4'b1111)
    ) u_col_sync (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .data_i    (col_n),
        .data_o    (col_sync)
    );

    // Columns are read on the last cycle of each row, after the strobe has settled.
    assign terminal  = &div_q;
    assign scan_done = terminal && (row_q == 2'd3);

    // Free-running divider; the row advances as the divider wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            row_q   <= 2'd0;
            row_n_q <= 4'b1110;
        end else begin
            div_q <= div_q + SCAN_DIV_BITS'(1);
            if (terminal) begin
                row_q   <= row_q + 2'd1;
                row_n_q <= ~(4'b0001 << (row_q + 2'd1));
            end
        end
    end

    // Fold this row's pressed columns into the scan totals; row 0 starts a fresh scan.
    always_comb begin
        acc_cnt_d  = (row_q == 2'd0) ? 2'd0 : acc_cnt_q;
        acc_code_d = (row_q == 2'd0) ? 4'd0 : acc_code_q;
        for (int c = 0; c < COLS; c++) begin
            if (!col_sync[c]) begin
                if (acc_cnt_d == 2'd0) begin
                    acc_code_d = {row_q, c[1:0]};
                end
                if (acc_cnt_d != 2'd2) begin
                    acc_cnt_d = acc_cnt_d + 2'd1;
                end
            end
        end
    end

    // Classify the finished scan from the totals including the row 3 sample.
    always_comb begin
        scan_class = SCAN_NONE;
        if (acc_cnt_d == 2'd1) begin
            scan_class = SCAN_SINGLE;
        end else if (acc_cnt_d == 2'd2) begin
            scan_class = SCAN_MULTI;
        end
    end

    // Hold the scan totals at each row sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (terminal) begin
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Debounce FSM stepped once per completed scan; ACCEPT lasts exactly one clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            rel_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_q       <= 6'd0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (scan_done && scan_class == SCAN_SINGLE) begin
                        cand_q  <= acc_code_d;
                        cnt_q   <= 4'd1;
                        state_q <= (DEB_CNT == 4'd1) ? ACCEPT : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (scan_done) begin
                        if (scan_class != SCAN_SINGLE) begin
                            state_q <= IDLE;
                        end else if (acc_code_d == cand_q) begin
                            if (cnt_q != 4'hF) begin
                                cnt_q <= cnt_q + 4'd1;
                            end
                            if (cnt_q + 4'd1 == DEB_CNT) begin
                                state_q <= ACCEPT;
                            end
                        end else begin
                            cand_q <= acc_code_d;
                            cnt_q  <= 4'd1;
                        end
                    end
                end
                ACCEPT: begin
                    key_code_q  <= cand_q;
                    key_valid_q <= 1'b1;
                    key_held_q  <= 1'b1;
                    rel_q       <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_q       <= 6'd0;
`endif
                    state_q     <= HELD;
                end
                HELD: begin
                    if (scan_done) begin
                        if (scan_class == SCAN_NONE) begin
                            if (rel_q != 4'hF) begin
                                rel_q <= rel_q + 4'd1;
                            end
                            if (rel_q + 4'd1 == DEB_CNT) begin
                                key_held_q <= 1'b0;
                                state_q    <= IDLE;
                            end
                        end else begin
                            rel_q <= 4'd0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        // Reloading DELAY-PERIOD makes later repeats come every PERIOD scans.
                        if (scan_class == SCAN_SINGLE && acc_code_d == key_code_q) begin
                            if (rpt_q + 6'd1 == 6'(AUTOREPEAT_DELAY)) begin
                                key_valid_q <= 1'b1;
                                rpt_q       <= 6'(AUTOREPEAT_DELAY - AUTOREPEAT_PERIOD);
                            end else begin
                                rpt_q <= rpt_q + 6'd1;
                            end
                        end else begin
                            rpt_q <= 6'd0;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV_BITS=2 (16 clocks per scan)
// and DEBOUNCE_SCANS=3. Expected pulses are queued with code and sample time.
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = 16'h0000;

    typedef struct {
        logic [3:0] code;
        longint     t;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     fails = 0;
    longint t_rel = 0;
    int     scan_idx = 0;

    always #5 clock = ~clock;

    // Physical keypad: a pressed key shorts its column to the strobed row.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV_BITS  (2),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Press the keys in mask m for n whole scans, starting just after a scan boundary.
    task automatic hold(input logic [15:0] m, input int n);
        pressed = m;
        repeat (16 * n) @(negedge clock);
        scan_idx += n;
    endtask

    // A pulse is expected `off` clocks after the row 3 sample closing scan number scan_end.
    task automatic expect_pulse(input logic [3:0] code, input int scan_end, input int off);
        exp_t e;
        e.code = code;
        e.t    = t_rel + longint'((16 * scan_end + off) * 10);
        exp_q.push_back(e);
    endtask

    task automatic release_reset();
        reset_n  = 1'b1;
        t_rel    = $time;
        scan_idx = 0;
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset_n && key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: got key_valid with code %0h at %0t, expected no pulse",
                         key_code, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("pulse code=%0h held=%0b at %0t (expected code=%0h at %0t)",
                         key_code, key_held, $time, e.code, e.t);
                check("pulse_code", 64'(key_code), 64'(e.code));
                check("pulse_time", 64'($time), 64'(e.t));
                check("pulse_held", 64'(key_held), 64'd1);
            end
        end
    end

    initial begin
        logic [3:0] exp_row;

        // Reset state
        pressed = 16'h0000;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_row_n", 64'(row_n), 64'(4'b1110));
        check("reset_key_code", 64'(key_code), 64'd0);
        check("reset_key_valid", 64'(key_valid), 64'd0);
        check("reset_key_held", 64'(key_held), 64'd0);
        release_reset();

        // Row strobe rotation with no keys
        for (int n = 0; n < 16; n++) begin
            if (n % 4 == 0) begin
                exp_row = ~(4'b0001 << (n / 4));
                check("row_n_rotation", 64'(row_n), 64'(exp_row));
            end
            @(negedge clock);
        end
        scan_idx = 1;
        hold(16'h0000, 1);
        check("idle_key_held", 64'(key_held), 64'd0);

        // Clean press of key 9 (row 2, col 1) and debounced release
        expect_pulse(4'h9, scan_idx + 3, 1);
        hold(16'h0001 << 9, 3);
        hold(16'h0000, 2);
        check("held_during_release", 64'(key_held), 64'd1);
        check("code_9", 64'(key_code), 64'h9);
        hold(16'h0000, 1);
        check("released_9", 64'(key_held), 64'd0);
        check("code_kept_after_release", 64'(key_code), 64'h9);

        // Contact bounce on key 5
        expect_pulse(4'h5, scan_idx + 6, 1);
        hold(16'h0001 << 5, 2);
        hold(16'h0000, 1);
        hold(16'h0001 << 5, 3);
        hold(16'h0000, 3);
        check("released_5", 64'(key_held), 64'd0);

        // Keys 0 and F together are ignored; key 0 alone is then accepted
        hold(16'h8001, 10);
        check("multi_not_held", 64'(key_held), 64'd0);
        expect_pulse(4'h0, scan_idx + 3, 1);
        hold(16'h0001, 3);
        hold(16'h0000, 3);

        // Key 3 accepted, roll straight to A: no new pulse until all released
        expect_pulse(4'h3, scan_idx + 3, 1);
        hold(16'h0001 << 3, 3);
        hold(16'h0001 << 10, 4);
        check("rollover_held", 64'(key_held), 64'd1);
        check("rollover_code", 64'(key_code), 64'h3);
        hold(16'h0000, 3);
        check("rollover_released", 64'(key_held), 64'd0);
        expect_pulse(4'hA, scan_idx + 3, 1);
        hold(16'h0001 << 10, 3);
        hold(16'h0000, 3);

        // Reset during the 2nd confirming scan of key 7
        pressed = 16'h0001 << 7;
        repeat (16 + 8) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_row_n", 64'(row_n), 64'(4'b1110));
        check("midreset_key_code", 64'(key_code), 64'd0);
        check("midreset_key_held", 64'(key_held), 64'd0);
        check("midreset_key_valid", 64'(key_valid), 64'd0);
        repeat (3) @(negedge clock);
        release_reset();
        expect_pulse(4'h7, 3, 1);
        hold(16'h0001 << 7, 3);
`ifdef KEYPAD_AUTOREPEAT_EN
        expect_pulse(4'h7, 35, 0);
        expect_pulse(4'h7, 43, 0);
        expect_pulse(4'h7, 51, 0);
        hold(16'h0001 << 7, 57);
`endif
        hold(16'h0000, 3);
        check("final_released", 64'(key_held), 64'd0);

        repeat (4) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulse: got %0d expected pulses never seen, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
